// File: rtl/bcd_scan_receiver.sv
// Receives a multiplexed 4-digit BCD display scan (ones..thousands), validates slot order
// and digit range, then converts the captured frame to binary over four cycles.
module bcd_scan_receiver #(
    parameter int CHECK_BCD = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  digit_in,
    input  logic [1:0]  slot,
    input  logic        slot_valid,
    output logic [3:0]  digit1,
    output logic [3:0]  digit2,
    output logic [3:0]  digit3,
    output logic [3:0]  digit4,
    output logic [13:0] bin_out,
    output logic        frame_done,
    output logic        bcd_error,
    output logic        seq_error,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_CONVERT
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_exp;
    logic [1:0]  r_cnt;
    logic [13:0] r_acc;
    logic [3:0]  r_sh0, r_sh1, r_sh2, r_sh3;
    logic        r_err;
    logic [3:0]  r_digit1, r_digit2, r_digit3, r_digit4;
    logic [13:0] r_bin;
    logic        r_done, r_bcd_err, r_seq_err, r_busy;

    logic [3:0]  w_digit;
    logic        w_bad;
    logic        w_accept0;
    logic        w_accept_n;
    logic        w_seq;
    logic [3:0]  w_conv_d;
    logic [13:0] w_acc_next;

    // With checking disabled, out-of-range digits saturate to 9 instead of flagging the frame.
    function automatic logic [3:0] sat_digit(input logic [3:0] d);
        logic [3:0] res;
        res = d;
        if (CHECK_BCD == 0 && d > 4'd9)
            res = 4'd9;
        return res;
    endfunction

    assign w_digit    = sat_digit(digit_in);
    assign w_bad      = (CHECK_BCD != 0) && (digit_in > 4'd9);
    assign w_accept0  = slot_valid && (slot == 2'd0) && (r_state != S_CONVERT);
    assign w_accept_n = slot_valid && (r_state == S_CAPTURE) && (slot != 2'd0) && (slot == r_exp);
    assign w_seq      = slot_valid && (r_state == S_CAPTURE) && (slot != 2'd0) && (slot != r_exp);

    // Most significant digit first: thousands, hundreds, tens, ones.
    always_comb begin
        w_conv_d = r_sh0;
        case (r_cnt)
            2'd0: w_conv_d = r_sh3;
            2'd1: w_conv_d = r_sh2;
            2'd2: w_conv_d = r_sh1;
            default: w_conv_d = r_sh0;
        endcase
    end

    assign w_acc_next = r_acc * 14'd10 + {10'd0, w_conv_d};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept0)
                    w_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (w_seq)
                    w_next = S_IDLE;
                else if (w_accept_n && slot == 2'd3)
                    w_next = S_CONVERT;
            end
            S_CONVERT: begin
                if (r_cnt == 2'd3)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_exp     <= 2'd0;
            r_cnt     <= 2'd0;
            r_acc     <= 14'd0;
            r_sh0     <= 4'd0;
            r_sh1     <= 4'd0;
            r_sh2     <= 4'd0;
            r_sh3     <= 4'd0;
            r_err     <= 1'b0;
            r_digit1  <= 4'd0;
            r_digit2  <= 4'd0;
            r_digit3  <= 4'd0;
            r_digit4  <= 4'd0;
            r_bin     <= 14'd0;
            r_done    <= 1'b0;
            r_bcd_err <= 1'b0;
            r_seq_err <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_bcd_err <= 1'b0;
            r_seq_err <= 1'b0;

            if (w_accept0) begin
                r_sh0 <= w_digit;
                r_exp <= 2'd1;
                r_err <= w_bad;
            end else if (w_accept_n) begin
                case (slot)
                    2'd1:    r_sh1 <= w_digit;
                    2'd2:    r_sh2 <= w_digit;
                    default: r_sh3 <= w_digit;
                endcase
                r_exp <= r_exp + 2'd1;
                r_err <= r_err | w_bad;
                if (slot == 2'd3) begin
                    r_acc  <= 14'd0;
                    r_cnt  <= 2'd0;
                    r_busy <= 1'b1;
                end
            end else if (w_seq) begin
                r_seq_err <= 1'b1;
                r_exp     <= 2'd0;
            end

            if (r_state == S_CONVERT) begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + 2'd1;
                if (r_cnt == 2'd3) begin
                    r_busy <= 1'b0;
                    if (!r_err) begin
                        r_bin    <= w_acc_next;
                        r_digit1 <= r_sh0;
                        r_digit2 <= r_sh1;
                        r_digit3 <= r_sh2;
                        r_digit4 <= r_sh3;
                        r_done   <= 1'b1;
                    end else begin
                        r_bcd_err <= 1'b1;
                    end
                end
            end
        end
    end

    assign digit1     = r_digit1;
    assign digit2     = r_digit2;
    assign digit3     = r_digit3;
    assign digit4     = r_digit4;
    assign bin_out    = r_bin;
    assign frame_done = r_done;
    assign bcd_error  = r_bcd_err;
    assign seq_error  = r_seq_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_bcd_scan_receiver.sv
// Directed bench for bcd_scan_receiver: one instance with BCD checking, one with clamping.
module tb_bcd_scan_receiver;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  digit_in = 4'd0;
    logic [1:0]  slot = 2'd0;
    logic        slot_valid = 1'b0;

    logic [3:0]  digit1, digit2, digit3, digit4;
    logic [13:0] bin_out;
    logic        frame_done, bcd_error, seq_error, busy;

    logic [3:0]  c_digit1, c_digit2, c_digit3, c_digit4;
    logic [13:0] c_bin_out;
    logic        c_frame_done, c_bcd_error, c_seq_error, c_busy;

    int checks = 0;
    int errors = 0;

    bcd_scan_receiver #(.CHECK_BCD(1)) dut (
        .clk(clk), .reset(reset), .digit_in(digit_in), .slot(slot), .slot_valid(slot_valid),
        .digit1(digit1), .digit2(digit2), .digit3(digit3), .digit4(digit4),
        .bin_out(bin_out), .frame_done(frame_done), .bcd_error(bcd_error),
        .seq_error(seq_error), .busy(busy)
    );

    bcd_scan_receiver #(.CHECK_BCD(0)) dut_clamp (
        .clk(clk), .reset(reset), .digit_in(digit_in), .slot(slot), .slot_valid(slot_valid),
        .digit1(c_digit1), .digit2(c_digit2), .digit3(c_digit3), .digit4(c_digit4),
        .bin_out(c_bin_out), .frame_done(c_frame_done), .bcd_error(c_bcd_error),
        .seq_error(c_seq_error), .busy(c_busy)
    );

    always #5 clk = ~clk;

    // Present one slot for one rising edge; returns 1 time unit after that edge.
    task automatic send_slot(input logic [1:0] s, input logic [3:0] d);
        slot_valid = 1'b1;
        slot       = s;
        digit_in   = d;
        @(posedge clk);
        #1;
        slot_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0] d0, input logic [3:0] d1,
                              input logic [3:0] d2, input logic [3:0] d3);
        send_slot(2'd0, d0);
        send_slot(2'd1, d1);
        send_slot(2'd2, d2);
        send_slot(2'd3, d3);
    endtask

    // Called just after edge N; counts busy over the four CONVERT cycles, returns just after N+4.
    task automatic wait_convert(output int nbusy);
        nbusy = busy ? 1 : 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            nbusy += busy ? 1 : 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({digit4, digit3, digit2, digit1, bin_out} !== 30'd0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", {digit4, digit3, digit2, digit1, bin_out});
        end
        checks++;
        if ({frame_done, bcd_error, seq_error, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0000", {frame_done, bcd_error, seq_error, busy});
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        send_slot(2'd1, 4'd1);
        send_slot(2'd2, 4'd2);
        send_slot(2'd3, 4'd3);
        checks++;
        if (seq_error !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_first_slot0: seq_error=%b busy=%b want 0 0", seq_error, busy);
        end
    endtask

    task automatic test_basic;
        int nb;
        send_frame(4'd4, 4'd3, 4'd2, 4'd1);
        wait_convert(nb);
        checks++;
        if (nb !== 4) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d want 4", nb);
        end
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: frame_done=%b busy=%b want 1 0", frame_done, busy);
        end
        checks++;
        if (bin_out !== 14'd1234) begin
            errors++;
            $display("FAIL basic_bin: got %0d want 1234", bin_out);
        end
        checks++;
        if ({digit1, digit2, digit3, digit4} !== 16'h4321) begin
            errors++;
            $display("FAIL basic_digits: got %h want 4321", {digit1, digit2, digit3, digit4});
        end
        @(posedge clk);
        #1;
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: got %b want 0", frame_done);
        end
    endtask

    task automatic test_back_to_back;
        int nb;
        int ndone;
        int nerr;
        ndone = 0;
        nerr  = 0;
        send_frame(4'd9, 4'd9, 4'd9, 4'd9);
        wait_convert(nb);
        ndone += frame_done ? 1 : 0;
        nerr  += (bcd_error | seq_error) ? 1 : 0;
        checks++;
        if (bin_out !== 14'd9999) begin
            errors++;
            $display("FAIL b2b_first_bin: got %0d want 9999", bin_out);
        end
        send_frame(4'd0, 4'd0, 4'd0, 4'd0);
        wait_convert(nb);
        ndone += frame_done ? 1 : 0;
        nerr  += (bcd_error | seq_error) ? 1 : 0;
        checks++;
        if (bin_out !== 14'd0 || ndone !== 2 || nerr !== 0) begin
            errors++;
            $display("FAIL b2b_second: bin=%0d dones=%0d errs=%0d want 0 2 0", bin_out, ndone, nerr);
        end
    endtask

    task automatic test_bcd;
        int nb;
        send_frame(4'd4, 4'd3, 4'd2, 4'd1);
        wait_convert(nb);
        send_frame(4'd4, 4'd3, 4'hA, 4'd1);
        wait_convert(nb);
        checks++;
        if (bcd_error !== 1'b1 || frame_done !== 1'b0 || bin_out !== 14'd1234) begin
            errors++;
            $display("FAIL bcd_reject: bcd_error=%b frame_done=%b bin=%0d want 1 0 1234",
                     bcd_error, frame_done, bin_out);
        end
        checks++;
        if (c_frame_done !== 1'b1 || c_bcd_error !== 1'b0 || c_bin_out !== 14'd1934) begin
            errors++;
            $display("FAIL bcd_clamp: frame_done=%b bcd_error=%b bin=%0d want 1 0 1934",
                     c_frame_done, c_bcd_error, c_bin_out);
        end
        checks++;
        if (c_digit3 !== 4'd9) begin
            errors++;
            $display("FAIL bcd_clamp_digit3: got %0d want 9", c_digit3);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bcd_error !== 1'b0) begin
            errors++;
            $display("FAIL bcd_pulse: got %b want 0", bcd_error);
        end
    endtask

    task automatic test_seq;
        int nb;
        send_slot(2'd0, 4'd5);
        send_slot(2'd1, 4'd6);
        send_slot(2'd3, 4'd7);
        checks++;
        if (seq_error !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL seq_abort: seq_error=%b busy=%b want 1 0", seq_error, busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (seq_error !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL seq_pulse: seq_error=%b frame_done=%b want 0 0", seq_error, frame_done);
        end
        send_frame(4'd5, 4'd6, 4'd7, 4'd8);
        wait_convert(nb);
        checks++;
        if (frame_done !== 1'b1 || bin_out !== 14'd8765) begin
            errors++;
            $display("FAIL seq_recover: frame_done=%b bin=%0d want 1 8765", frame_done, bin_out);
        end
    endtask

    task automatic test_resync;
        int nb;
        int nseq;
        nseq = 0;
        send_slot(2'd0, 4'd9);
        nseq += seq_error ? 1 : 0;
        send_slot(2'd1, 4'd9);
        nseq += seq_error ? 1 : 0;
        send_slot(2'd0, 4'd1);
        nseq += seq_error ? 1 : 0;
        send_slot(2'd1, 4'd2);
        nseq += seq_error ? 1 : 0;
        send_slot(2'd2, 4'd3);
        nseq += seq_error ? 1 : 0;
        send_slot(2'd3, 4'd4);
        nseq += seq_error ? 1 : 0;
        wait_convert(nb);
        checks++;
        if (nseq !== 0 || frame_done !== 1'b1 || bin_out !== 14'd4321) begin
            errors++;
            $display("FAIL resync: seq=%0d frame_done=%b bin=%0d want 0 1 4321", nseq, frame_done, bin_out);
        end
    endtask

    task automatic test_convert_ignore;
        send_frame(4'd8, 4'd7, 4'd6, 4'd5);
        send_slot(2'd0, 4'd3);
        repeat (2) @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checks++;
        if (frame_done !== 1'b1 || bin_out !== 14'd5678 || seq_error !== 1'b0) begin
            errors++;
            $display("FAIL convert_ignore: frame_done=%b bin=%0d seq=%b want 1 5678 0",
                     frame_done, bin_out, seq_error);
        end
        send_slot(2'd2, 4'd1);
        checks++;
        if (seq_error !== 1'b0) begin
            errors++;
            $display("FAIL convert_ignore_idle: seq_error=%b want 0", seq_error);
        end
    endtask

    task automatic test_reset_convert;
        int ndone;
        ndone = 0;
        send_frame(4'd1, 4'd1, 4'd1, 4'd1);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({digit4, digit3, digit2, digit1, bin_out} !== 30'd0 ||
            {frame_done, bcd_error, seq_error, busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_async_convert: data=%h ctrl=%b want 0",
                     {digit4, digit3, digit2, digit1, bin_out}, {frame_done, bcd_error, seq_error, busy});
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            ndone += (frame_done | bcd_error | busy) ? 1 : 0;
        end
        checks++;
        if (ndone !== 0 || bin_out !== 14'd0) begin
            errors++;
            $display("FAIL reset_convert_release: activity=%0d bin=%0d want 0 0", ndone, bin_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_bcd();
        test_seq();
        test_resync();
        test_convert_ignore();
        test_reset_convert();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
